// File: rtl/switch_drain_arb.sv
// Output drain scheduler: grants one switch output FIFO at a time, pops it, forwards words on a valid/ready stream.
// Build option: define DRAIN_ARB_STRICT_PRIO_EN for fixed lowest-index priority instead of round-robin.
module switch_drain_arb #(
  parameter int NUM_OF_PORTS = 4,
  parameter int WORD_WIDTH   = 8,
  parameter int MAX_BURST    = 4,
  localparam int PW = $clog2(NUM_OF_PORTS),
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_OF_PORTS-1:0]            port_ready,
  input  logic [NUM_OF_PORTS*WORD_WIDTH-1:0] port_out,
  output logic [NUM_OF_PORTS-1:0]            port_read,
  output logic [WORD_WIDTH-1:0]              out_data,
  output logic [PW-1:0]                      out_port,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               busy
);

  typedef enum logic [1:0] {IDLE, READ, CAPT, HOLD} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] grant, sel, last_grant;
  logic [CW-1:0] burst_cnt, burst_inc;
  logic          accept, burst_more;

  logic [NUM_OF_PORTS-1:0][WORD_WIDTH-1:0] port_words;
  assign port_words = port_out;

  assign accept     = (state == HOLD) && out_ready;
  assign burst_inc  = burst_cnt + CW'(1);
  // A FIFO emptied by the last pop simply ends the burst.
  assign burst_more = (burst_inc < CW'(MAX_BURST)) && port_ready[grant];
  assign busy       = (state != IDLE);

`ifdef DRAIN_ARB_STRICT_PRIO_EN
  always_comb begin
    sel = '0;
    for (int i = NUM_OF_PORTS-1; i >= 0; i--)
      if (port_ready[PW'(i)]) sel = PW'(i);
  end
`else
  logic [PW-1:0] rr_idx;
  logic          sel_ok;

  // Search starts just after the previous grant so every ready port gets a turn.
  always_comb begin
    sel    = '0;
    sel_ok = 1'b0;
    rr_idx = '0;
    for (int k = 1; k <= NUM_OF_PORTS; k++) begin
      rr_idx = PW'((int'(last_grant) + k) % NUM_OF_PORTS);
      if (!sel_ok && port_ready[rr_idx]) begin
        sel    = rr_idx;
        sel_ok = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    port_read = '0;
    case (state)
      IDLE: if (|port_ready) state_nxt = READ;
      READ: begin
        port_read[grant] = 1'b1;
        state_nxt        = CAPT;
      end
      CAPT: state_nxt = HOLD;
      HOLD: if (accept) state_nxt = burst_more ? READ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= '0;
      last_grant <= PW'(NUM_OF_PORTS - 1);
      burst_cnt  <= '0;
      out_data   <= '0;
      out_port   <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|port_ready) begin
          grant     <= sel;
          burst_cnt <= '0;
        end
        CAPT: begin
          out_data  <= port_words[grant];
          out_port  <= grant;
          out_valid <= 1'b1;
        end
        HOLD: if (accept) begin
          out_valid <= 1'b0;
          burst_cnt <= burst_inc;
          if (!burst_more) last_grant <= grant;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_drain_arb.sv
// Bench for switch_drain_arb: FIFO models with registered read, output scoreboard, cycle table for the basic burst.
module tb_switch_drain_arb;
  localparam int N = 4, W = 8, MB = 4, PW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     port_ready;
  logic [N-1:0][W-1:0] port_words;
  logic [N*W-1:0]   port_out;
  logic [N-1:0]     port_read;
  logic [W-1:0]     out_data;
  logic [PW-1:0]    out_port;
  logic             out_valid, out_ready, busy;

  assign port_out = port_words;
  always #5 clk = ~clk;

  switch_drain_arb #(.NUM_OF_PORTS(N), .WORD_WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .port_ready(port_ready), .port_out(port_out),
    .port_read(port_read), .out_data(out_data), .out_port(out_port),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  typedef struct packed { logic [PW-1:0] port; logic [W-1:0] data; } item_t;
  typedef struct {
    logic rdy; logic [N-1:0] rd; logic vld; logic [W-1:0] data;
    logic [PW-1:0] port; logic bsy; logic dchk;
  } vec_t;

  item_t        sb[$];
  logic [W-1:0] mem [N][16];
  int           head [N];
  int           tail [N];
  logic [N-1:0] rd_seen;
  int           tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic load(input int p, input logic [W-1:0] w);
    mem[p][tail[p] % 16] = w;
    tail[p]++;
    port_ready[p] = 1'b1;
  endtask

  task automatic expect_out(input int p, input logic [W-1:0] w);
    item_t it;
    it.port = PW'(p);
    it.data = w;
    sb.push_back(it);
  endtask

  // Mid-cycle: invariants on port_read and scoreboard compare on every accept.
  task automatic watch();
    item_t e;
    @(negedge clk);
    rd_seen = port_read;
    chk("read_onehot", 32'($countones(port_read) <= 1), 32'd1);
    chk("read_to_ready", 32'(port_read & ~port_ready), 32'd0);
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out: got port %0d data %0h, expected no output", out_port, out_data);
      end else begin
        e = sb.pop_front();
        chk("out_port", 32'(out_port), 32'(e.port));
        chk("out_data", 32'(out_data), 32'(e.data));
      end
    end
  endtask

  // Clock edge; FIFOs pop on the strobe seen this cycle and present the word next cycle.
  task automatic advance();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rd_seen[i] && head[i] != tail[i]) begin
        port_words[i] = mem[i][head[i] % 16];
        head[i]++;
      end
      port_ready[i] = (head[i] != tail[i]);
    end
  endtask

  task automatic tick();
    watch();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < max_cyc) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(n < max_cyc), 32'd1);
  endtask

  initial begin
    vec_t vt[9];
    int   n, pulses;

    vt[0] = '{1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1};
    vt[1] = '{1'b1, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b1, 1'b1};
    vt[2] = '{1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b1, 1'b1};
    vt[3] = '{1'b1, 4'b0000, 1'b1, 8'hA1, 2'd0, 1'b1, 1'b1};
    vt[4] = '{1'b1, 4'b0001, 1'b0, 8'hA1, 2'd0, 1'b1, 1'b0};
    vt[5] = '{1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0};
    vt[6] = '{1'b1, 4'b0000, 1'b1, 8'hA2, 2'd0, 1'b1, 1'b1};
    vt[7] = '{1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
    vt[8] = '{1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};

    rst = 1'b1; out_ready = 1'b0; port_ready = '0; port_words = '0; rd_seen = '0;
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end

    // Two words from port 0, cycle by cycle.
    do_reset();
    load(0, 8'hA1); load(0, 8'hA2);
    expect_out(0, 8'hA1); expect_out(0, 8'hA2);
    for (int v = 0; v < 9; v++) begin
      out_ready = vt[v].rdy;
      watch();
      chk($sformatf("tbl%0d_read", v), 32'(port_read), 32'(vt[v].rd));
      chk($sformatf("tbl%0d_valid", v), 32'(out_valid), 32'(vt[v].vld));
      chk($sformatf("tbl%0d_busy", v), 32'(busy), 32'(vt[v].bsy));
      if (vt[v].dchk) begin
        chk($sformatf("tbl%0d_data", v), 32'(out_data), 32'(vt[v].data));
        chk($sformatf("tbl%0d_port", v), 32'(out_port), 32'(vt[v].port));
      end
      advance();
    end
    chk("tbl_sb_empty", 32'(sb.size()), 32'd0);

    // One word on every port: order 0,1,2,3.
    do_reset();
    out_ready = 1'b1;
    for (int p = 0; p < N; p++) begin
      load(p, 8'((p + 1) * 16));
      expect_out(p, 8'((p + 1) * 16));
    end
    drain(200);

    // Port 2 deeper than a burst, port 1 joins after the grant.
    do_reset();
    for (int k = 0; k < 6; k++) load(2, 8'(8'h21 + k));
    for (int k = 0; k < 4; k++) expect_out(2, 8'(8'h21 + k));
    expect_out(1, 8'h11);
    expect_out(2, 8'h25); expect_out(2, 8'h26);
    tick(); tick();
    load(1, 8'h11);
    drain(300);

    // Downstream stall during HOLD.
    do_reset();
    out_ready = 1'b0;
    load(3, 8'h31); load(3, 8'h32);
    expect_out(3, 8'h31); expect_out(3, 8'h32);
    n = 0;
    do begin tick(); n++; end while (!out_valid && n < 20);
    chk("first_latency", 32'(n), 32'd3);
    for (int c = 0; c < 10; c++) begin
      watch();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'h31);
      chk("stall_port", 32'(out_port), 32'd3);
      chk("stall_read", 32'(port_read), 32'd0);
      advance();
    end
    out_ready = 1'b1;
    tick();
    watch();
    chk("resume_read", 32'(port_read), 32'b1000);
    advance();
    drain(100);

    // Reset in CAPT of the second word; popped word is lost, port 0 wins next.
    do_reset();
    load(1, 8'h51); load(1, 8'h52); load(1, 8'h53);
    expect_out(1, 8'h51);
    n = 0; pulses = 0;
    while (pulses < 2 && n < 30) begin
      watch();
      if (port_read != '0) pulses++;
      advance();
      n++;
    end
    chk("capt_reached", 32'(pulses), 32'd2);
    chk("capt_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    load(0, 8'h05);
    tick();
    rst = 1'b0;
    chk("sb_pre_reset", 32'(sb.size()), 32'd0);
    sb.delete();
    expect_out(0, 8'h05); expect_out(1, 8'h53);
    watch();
    chk("rst_read", 32'(port_read), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_port", 32'(out_port), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    advance();
    drain(100);

    // Arbitration policy after port 1 was last granted.
    do_reset();
    load(1, 8'h61); expect_out(1, 8'h61);
    drain(100);
    load(0, 8'h60); load(3, 8'h63);
`ifdef DRAIN_ARB_STRICT_PRIO_EN
    expect_out(0, 8'h60); expect_out(3, 8'h63);
`else
    expect_out(3, 8'h63); expect_out(0, 8'h60);
`endif
    drain(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/switch_drain_arb.md
# switch_drain_arb

Output drain scheduler for the switch: watches the per-port ready flags of the NUM_OF_PORTS output FIFOs, grants one port at a time, pulses that port's read strobe, and forwards the popped words onto a single valid/ready output stream tagged with the source port. It sits directly behind the switch's per-port output bus, `port_ready`, and `port_read` lines. It is the only agent driving `port_read`.

## Interface
- `NUM_OF_PORTS`, 4, number of switch output ports (≥2)
- `WORD_WIDTH`, 8, data word width
- `MAX_BURST`, 4, max words drained from one port per grant (≥1)
- `clk` input 1: single clock, all logic on rising edge
- `rst` input 1: reset, synchronous, active-high
- `port_ready` input NUM_OF_PORTS: bit i high = FIFO i non-empty
- `port_out` input NUM_OF_PORTS*WORD_WIDTH: FIFO i data on bits [(i+1)*WORD_WIDTH-1 : i*WORD_WIDTH]
- `port_read` output NUM_OF_PORTS: one-hot pop strobe, at most one bit high per cycle
- `out_data` output WORD_WIDTH: forwarded word
- `out_port` output $clog2(NUM_OF_PORTS): source port of `out_data`
- `out_valid` output 1: `out_data`/`out_port` valid
- `out_ready` input 1: downstream accepts when `out_valid && out_ready`
- `busy` output 1: high in any state other than IDLE

## Operation
- FSM states: IDLE, READ, CAPT, HOLD.
- IDLE: if `|port_ready`, select grant g (see arbitration), clear burst counter, go READ; else stay.
- READ: `port_read[g]`=1 for exactly this cycle; go CAPT.
- CAPT: FIFO g presents popped word on its `port_out` slice this cycle; register it into `out_data`, set `out_port`=g, `out_valid`=1; go HOLD.
- HOLD: hold `out_data`/`out_port`/`out_valid` stable until `out_ready`. On accept: burst counter +1; if new count < MAX_BURST and `port_ready[g]`=1, go READ; else set last_grant=g, go IDLE. `out_valid` drops the cycle after accept.
- Arbitration (default): round-robin; search ports last_grant+1, last_grant+2, … modulo NUM_OF_PORTS, first ready wins. last_grant resets to NUM_OF_PORTS-1, so port 0 has first priority after reset.
- Burst counter width $clog2(MAX_BURST+1); it never wraps. MAX_BURST=1 gives one word per grant.
- `port_ready[g]` falling during HOLD (FIFO emptied by the pop) ends the burst normally. Ready changes on non-granted ports never affect the current burst.
- `port_read` is decoded from state and g only; it never depends on `out_ready` combinationally.
- Reset (any state, including mid-burst): state=IDLE, `port_read`=0, `out_valid`=0, `out_data`=0, `out_port`=0, `busy`=0, burst counter=0, last_grant=NUM_OF_PORTS-1. A word popped but not yet accepted is discarded.

## Timing
- The FIFO read is registered: data valid on `port_out` one cycle after the `port_read` pulse.
- Cycle n: IDLE sees ready. n+1: READ. n+2: CAPT. n+3: `out_valid`=1. First-word latency is 3 cycles.
- With `out_ready` held high, each further word in a burst takes 3 cycles (HOLD→READ→CAPT→HOLD).
- Between bursts, HOLD→IDLE→READ adds 1 arbitration cycle.
- `out_valid` never deasserts without an accept, except on reset.

## Configuration
- `DRAIN_ARB_STRICT_PRIO_EN` defined: arbitration is fixed priority, lowest ready index wins. last_grant is not used for selection.
- Not defined: round-robin as above.
- FSM, burst, and timing behaviour are identical in both builds.

## Test plan
- Reset, then `port_ready`=4'b0001 with 2 words 0xA1, 0xA2 in FIFO 0, `out_ready`=1 → `port_read`=0001 in cycles 1 and 4; `out_data`=0xA1 then 0xA2, `out_port`=0; IDLE after port_ready falls.
- All 4 ports hold 1 word each (0x10, 0x20, 0x30, 0x40), round-robin → output order ports 0,1,2,3. With `DRAIN_ARB_STRICT_PRIO_EN` and port 0 continuously refilled → port 0 only.
- Port 2 holds 6 words, MAX_BURST=4, port 1 also ready after grant → 4 words from port 2, then port 1 granted, then the remaining 2 words from port 2.
- `out_ready`=0 for 10 cycles during HOLD → `out_data`/`out_port` stable, `out_valid`=1, no `port_read` pulses; drain resumes 1 cycle after `out_ready`=1.
- Assert `rst` in CAPT mid-burst → next cycle all outputs 0, state IDLE; the next grant goes to port 0 if ready.
- Every cycle, check `$countones(port_read)` ≤ 1 and that `port_read` is only asserted to a port whose `port_ready` is 1.
